vote_input_conditioner: RTL and testbench

VOTE_INPUT_CONDITIONER -- requirements
Module: vote_input_conditioner

---
 rtl/vote_input_conditioner.sv | 110 +++++++++++
 tb/tb_vote_input_conditioner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_input_conditioner.sv
// Vote input conditioner: synchronizes and debounces four buttons, then
// emits one vote (or a reject) per press followed by a lockout window.
module vote_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       enable,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       reject
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LK_LAST = 8'(LOCKOUT_CYCLES - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t     state;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] vote;
  logic [7:0] dcnt [4];
  logic [7:0] lcnt;
  logic       multi;

  assign a = vote[0];
  assign b = vote[1];
  assign c = vote[2];
  assign d = vote[3];

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign multi = |(rise & (rise - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // rise is a registered one-cycle strobe of each 0->1 level toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      rise  <= '0;
      for (int i = 0; i < 4; i++)
        dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rise[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] >= DB_LAST) begin
          dcnt[i]  <= '0;
          level[i] <= ~level[i];
          rise[i]  <= ~level[i];
        end else begin
          dcnt[i] <= dcnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lcnt   <= '0;
      vote   <= '0;
      busy   <= 1'b0;
      reject <= 1'b0;
    end else begin
      vote   <= '0;
      reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && (rise != 4'd0)) begin
            state <= LOCK;
            lcnt  <= '0;
            busy  <= 1'b1;
            if (multi)
              reject <= 1'b1;
            else
              vote <= rise;
          end
        end
        LOCK: begin
          if ((lcnt >= LK_LAST) && (level == 4'd0)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (lcnt != 8'hFF) begin
            lcnt <= lcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner at default parameters.
// Expected cycle counts are derived by hand from the latency rules.
module tb_vote_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       enable = 1'b1;
  logic       a, b, c, d, busy, reject;

  int vectors = 0;
  int miscompares = 0;
  int na = 0, nb = 0, nc = 0, nd = 0, nr = 0;
  int onehot_err = 0;

  vote_input_conditioner dut (
    .clk(clk), .rst(rst), .btn(btn), .enable(enable),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .reject(reject)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a === 1'b1) na++;
    if (b === 1'b1) nb++;
    if (c === 1'b1) nc++;
    if (d === 1'b1) nd++;
    if (reject === 1'b1) nr++;
    if ((32'(a) + 32'(b) + 32'(c) + 32'(d) + 32'(reject)) > 1)
      onehot_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== exp) begin
      miscompares++;
      $display("FAIL %s busy_fall cycles=%0d exp=%0d", name, n, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'b1111;
    repeat (3) tick();
    vectors++;
    if ({a, b, c, d, busy, reject} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset outs=%b exp=000000",
               {a, b, c, d, busy, reject});
    end
    btn = 4'd0;
    rst = 1'b0;
    repeat (12) tick();
    vectors++;
    if ({a, b, c, d, busy, reject} !== 6'd0) begin
      miscompares++;
      $display("FAIL post_reset outs=%b exp=000000",
               {a, b, c, d, busy, reject});
    end
  endtask

  task automatic test_single_vote();
    int a0 = na, b0 = nb, c0 = nc, d0 = nd, r0 = nr;
    btn = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (a !== (k == 7)) begin
        miscompares++;
        $display("FAIL single_lat edge=%0d a=%b exp=%b", k, a, k == 7);
      end
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy busy=%b exp=1", busy);
    end
    for (int k = 8; k <= 20; k++) begin
      tick();
      vectors++;
      if (a !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL single_hold edge=%0d a=%b busy=%b exp a=0 busy=1",
                 k, a, busy);
      end
    end
    btn = 4'd0;
    wait_idle("single", 7);
    tick();
    vectors++;
    if ((na - a0) !== 1 || (nb - b0 + nc - c0 + nd - d0 + nr - r0) !== 0) begin
      miscompares++;
      $display("FAIL single_counts a=%0d others=%0d exp a=1 others=0",
               na - a0, nb - b0 + nc - c0 + nd - d0 + nr - r0);
    end
  endtask

  task automatic test_glitch();
    int b0 = nb;
    int busy_seen = 0;
    btn = 4'b0010;
    repeat (3) tick();
    btn = 4'd0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (busy === 1'b1) busy_seen++;
    end
    vectors++;
    if ((nb - b0) !== 0 || busy_seen !== 0) begin
      miscompares++;
      $display("FAIL glitch b_pulses=%0d busy_cycles=%0d exp 0 0",
               nb - b0, busy_seen);
    end
  endtask

  task automatic test_reject();
    int v0 = na + nb + nc + nd;
    int r0 = nr;
    btn = 4'b0110;
    repeat (7) tick();
    vectors++;
    if (reject !== 1'b1 || {a, b, c, d} !== 4'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_pulse rej=%b abcd=%b busy=%b exp 1 0000 1",
               reject, {a, b, c, d}, busy);
    end
    tick();
    vectors++;
    if (reject !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_after rej=%b busy=%b exp 0 1", reject, busy);
    end
    repeat (5) tick();
    btn = 4'd0;
    wait_idle("reject", 7);
    tick();
    vectors++;
    if ((nr - r0) !== 1 || (na + nb + nc + nd - v0) !== 0) begin
      miscompares++;
      $display("FAIL reject_counts rej=%0d votes=%0d exp 1 0",
               nr - r0, na + nb + nc + nd - v0);
    end
  endtask

  task automatic test_revote();
    int c0 = nc;
    btn = 4'b0100;
    repeat (30) tick();
    vectors++;
    if ((nc - c0) !== 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL revote_held c=%0d busy=%b exp 1 1", nc - c0, busy);
    end
    btn = 4'd0;
    wait_idle("revote_rel1", 7);
    btn = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (c !== (k == 7)) begin
        miscompares++;
        $display("FAIL revote_lat edge=%0d c=%b exp=%b", k, c, k == 7);
      end
    end
    repeat (4) tick();
    btn = 4'd0;
    wait_idle("revote_rel2", 7);
    tick();
    vectors++;
    if ((nc - c0) !== 2) begin
      miscompares++;
      $display("FAIL revote_count c=%0d exp=2", nc - c0);
    end
  endtask

  task automatic test_enable();
    int d0 = nd;
    enable = 1'b0;
    btn = 4'b1000;
    repeat (12) tick();
    enable = 1'b1;
    repeat (12) tick();
    vectors++;
    if ((nd - d0) !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_held d=%0d busy=%b exp 0 0", nd - d0, busy);
    end
    btn = 4'd0;
    repeat (10) tick();
    btn = 4'b1000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (d !== (k == 7)) begin
        miscompares++;
        $display("FAIL enable_repress edge=%0d d=%b exp=%b", k, d, k == 7);
      end
    end
    repeat (4) tick();
    btn = 4'd0;
    wait_idle("enable", 7);
  endtask

  task automatic test_reset_lock();
    int a0 = na;
    btn = 4'b0001;
    repeat (7) tick();
    vectors++;
    if (a !== 1'b1) begin
      miscompares++;
      $display("FAIL rstlock_vote a=%b exp=1", a);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || a !== 1'b0) begin
      miscompares++;
      $display("FAIL rstlock_busy busy=%b a=%b exp 0 0", busy, a);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (a !== (k == 7)) begin
        miscompares++;
        $display("FAIL rstlock_revote edge=%0d a=%b exp=%b", k, a, k == 7);
      end
    end
    repeat (3) tick();
    btn = 4'd0;
    wait_idle("rstlock", 7);
    tick();
    vectors++;
    if ((na - a0) !== 2) begin
      miscompares++;
      $display("FAIL rstlock_count a=%0d exp=2", na - a0);
    end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_glitch();
    test_reject();
    test_revote();
    test_enable();
    test_reset_lock();
    vectors++;
    if (onehot_err !== 0) begin
      miscompares++;
      $display("FAIL onehot cycles=%0d exp=0", onehot_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
